sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//  Two-master arbiter sharing the single picorv32_sram native port between the
//  PicoRV32 core (m0) and a second bus master (m1, e.g. UART boot loader / DMA).
//  Sits between the masters and u_sram in the top level; serialises requests,
//  round-robin or fixed priority, one transaction per grant, with a watchdog
//  that completes hung transactions with an error response.
// PARAMETERS
//  ADDR_W   32           address width forwarded to the slave
//  TIMEOUT  1024         max cycles a granted access waits for s_mem_ready; 0 = watchdog off
//  RR_EN    1            1 = round-robin, 0 = fixed priority (m0 always wins)
//  ERR_DATA 32'hDEAD_BEEF rdata returned on a timed-out access
// PORTS
//  clk           in   1       system clock
//  resetn        in   1       asynchronous active-low reset
//  m0_mem_valid  in   1       core request (held until m0_mem_ready)
//  m0_mem_addr   in   ADDR_W  core address
//  m0_mem_wdata  in   32      core write data
//  m0_mem_wstrb  in   4       core byte strobes, 0 = read
//  m0_mem_ready  out  1       core completion pulse
//  m0_mem_rdata  out  32      core read data
//  m1_mem_*      —    —       same six signals for master 1
//  s_mem_valid   out  1       to SRAM
//  s_mem_addr    out  ADDR_W  to SRAM
//  s_mem_wdata   out  32      to SRAM
//  s_mem_wstrb   out  4       to SRAM
//  s_mem_ready   in   1       from SRAM
//  s_mem_rdata   in   32      from SRAM
//  bus_err       out  1       one-cycle pulse on watchdog expiry
//  err_master    out  1       master id of last timed-out access (sticky until next error)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, last_grant=1 (m0 wins first tie),
//    wdog=0; all outputs 0 incl. s_mem_valid, m*_mem_ready, bus_err, err_master.
//  - FSM states IDLE, GNT0, GNT1, DONE.
//  - IDLE: pick requester; both valid -> RR_EN ? the one != last_grant : m0.
//    Registered grant: request at edge N -> state GNTx after N, s_mem_valid high
//    in cycle N+1. No request -> stay IDLE.
//  - GNTx: s_mem_* = mx signals (combinational mux on state), s_mem_valid = mx_mem_valid.
//    mx_mem_ready = s_mem_ready, mx_mem_rdata = s_mem_rdata (combinational).
//    Other master's ready stays 0, its rdata = 0. On s_mem_ready: last_grant<=x,
//    -> DONE. Master dropping valid without ready (illegal) -> IDLE, no ready.
//  - DONE: one cycle, s_mem_valid=0 (guarantees slave sees valid low between
//    transactions); -> IDLE. Back-to-back same master: 3-cycle turnaround min.
//  - Watchdog: wdog counts cycles in GNTx, cleared on entry; if TIMEOUT!=0 and
//    wdog==TIMEOUT-1 with no s_mem_ready: mx_mem_ready=1, mx_mem_rdata=ERR_DATA,
//    bus_err=1, err_master<=x, -> DONE. s_mem_ready same cycle as expiry wins
//    (normal completion, no error). Counter width $clog2(TIMEOUT+1), no wrap.
//  - Write data/strobes pass through unmodified; arbiter never alters wstrb.
//  - Simultaneous new request and completion: new request evaluated only in IDLE.
//  - Reset mid-transaction: outputs drop asynchronously; no completion issued.
// STRUCTURE
//  - Shared package: state encoding (IDLE/GNT0/GNT1/DONE), master-id constants,
//    ERR_DATA default.
//  - One sub-module natural: rr_arb2 (2-way grant pick from req[1:0], last_grant,
//    RR_EN); FSM, mux and watchdog in sram_bus_arbiter.
// TESTING
//  1 Reset: resetn=0 mid-GNT0 -> s_mem_valid, m0_mem_ready, bus_err =0 same cycle; IDLE after release.
//  2 m0 read 0x100 alone, SRAM ready after 1 cycle, rdata 0x1234_5678 -> m0_mem_rdata=0x1234_5678, m1_mem_ready never 1.
//  3 Both valid at once, RR_EN=1, from reset -> m0 served first, then m1; repeat -> alternation m0,m1,m0,m1.
//  4 RR_EN=0, m0 and m1 continuously valid -> m1 never granted while m0 requests.
//  5 TIMEOUT=8, SRAM ready tied 0, m1 write -> m1_mem_ready at 8th GNT1 cycle, rdata 0xDEADBEEF, bus_err pulse, err_master=1.
//  6 TIMEOUT=8, s_mem_ready on cycle 8 -> normal data, bus_err stays 0; DONE cycle shows s_mem_valid=0.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the two-master SRAM bus arbiter.
// Holds the FSM state encoding, master-id constants and the default error word.
// Pure declarations; no logic, no timing.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MID_M0 = 1'b0;
    localparam logic MID_M1 = 1'b1;

    // Read data handed back to a master whose access was killed by the watchdog
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_bus_arbiter_rr_arb2.sv
// Two-way grant picker: chooses which pending master gets the next access.
// Latency: purely combinational, result is registered by the caller.
// Backpressure: none; only evaluated while the caller is idle.
module sram_bus_arbiter_rr_arb2
    import sram_bus_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_vld,
    output logic       gnt_id
);

    // On a tie, round-robin favours the master that was not served last;
    // fixed priority always favours m0.
    always_comb begin
        gnt_vld = |req;
        gnt_id  = MID_M0;
        if (req == 2'b11) begin
            gnt_id = RR_EN ? ~last_grant : MID_M0;
        end else if (req[1]) begin
            gnt_id = MID_M1;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Serialises two native-port masters onto one SRAM port with a hang watchdog.
// Latency: request sampled in IDLE, slave sees valid next cycle; DONE adds one idle cycle.
// Backpressure: masters hold valid until their ready pulse; the loser waits in place.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          TIMEOUT  = 1024,
    parameter bit          RR_EN    = 1'b1,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              m0_mem_valid,
    input  logic [ADDR_W-1:0] m0_mem_addr,
    input  logic [31:0]       m0_mem_wdata,
    input  logic [3:0]        m0_mem_wstrb,
    output logic              m0_mem_ready,
    output logic [31:0]       m0_mem_rdata,

    input  logic              m1_mem_valid,
    input  logic [ADDR_W-1:0] m1_mem_addr,
    input  logic [31:0]       m1_mem_wdata,
    input  logic [3:0]        m1_mem_wstrb,
    output logic              m1_mem_ready,
    output logic [31:0]       m1_mem_rdata,

    output logic              s_mem_valid,
    output logic [ADDR_W-1:0] s_mem_addr,
    output logic [31:0]       s_mem_wdata,
    output logic [3:0]        s_mem_wstrb,
    input  logic              s_mem_ready,
    input  logic [31:0]       s_mem_rdata,

    output logic              bus_err,
    output logic              err_master
);

    // Counter is wide enough to hold TIMEOUT; a disabled watchdog keeps a 1-bit stub.
    localparam bit              WD_ON   = (TIMEOUT != 0);
    localparam int              WD_W    = WD_ON ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_ON ? TIMEOUT - 1 : 0);
    localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

    state_t          state;
    logic            last_grant;
    logic [WD_W-1:0] wdog;

    logic            gnt_vld;
    logic            gnt_id;
    logic            in_gnt;
    logic            cur_id;
    logic            cur_vld;
    logic            expire;

    sram_bus_arbiter_rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_rr_arb2 (
        .req        ({m1_mem_valid, m0_mem_valid}),
        .last_grant (last_grant),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id)
    );

    // Decode the owning master and detect watchdog expiry; a slave ready in the
    // expiry cycle takes precedence so a late but valid answer is not discarded.
    always_comb begin
        in_gnt  = (state == ST_GNT0) || (state == ST_GNT1);
        cur_id  = (state == ST_GNT1);
        cur_vld = cur_id ? m1_mem_valid : m0_mem_valid;
        expire  = WD_ON && in_gnt && cur_vld && !s_mem_ready && (wdog == WD_LAST);
    end

    // Steer the owning master onto the slave port and route the response back;
    // the non-owning master sees ready=0 and rdata=0.
    always_comb begin
        s_mem_valid  = 1'b0;
        s_mem_addr   = '0;
        s_mem_wdata  = '0;
        s_mem_wstrb  = '0;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = '0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = '0;
        bus_err      = expire;
        case (state)
            ST_GNT0: begin
                s_mem_valid  = m0_mem_valid;
                s_mem_addr   = m0_mem_addr;
                s_mem_wdata  = m0_mem_wdata;
                s_mem_wstrb  = m0_mem_wstrb;
                m0_mem_ready = (m0_mem_valid && s_mem_ready) || expire;
                m0_mem_rdata = expire ? ERR_DATA : s_mem_rdata;
            end
            ST_GNT1: begin
                s_mem_valid  = m1_mem_valid;
                s_mem_addr   = m1_mem_addr;
                s_mem_wdata  = m1_mem_wdata;
                s_mem_wstrb  = m1_mem_wstrb;
                m1_mem_ready = (m1_mem_valid && s_mem_ready) || expire;
                m1_mem_rdata = expire ? ERR_DATA : s_mem_rdata;
            end
            default: ;
        endcase
    end

    // Grant FSM with watchdog: one transaction per grant, then a forced idle cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            last_grant <= MID_M1;
            wdog       <= '0;
            err_master <= MID_M0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (gnt_vld) begin
                        state <= gnt_id ? ST_GNT1 : ST_GNT0;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (!cur_vld) begin
                        // Master withdrew without completion: abandon quietly
                        state <= ST_IDLE;
                    end else if (s_mem_ready) begin
                        last_grant <= cur_id;
                        state      <= ST_DONE;
                    end else if (expire) begin
                        err_master <= cur_id;
                        state      <= ST_DONE;
                    end else if (wdog != WD_MAX) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_DONE: begin
                    wdog  <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter.
// Two instances share stimulus: u_a is round-robin, u_b is fixed priority, both TIMEOUT=8.
// The SRAM side is driven by hand so every response cycle is explicit.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    logic        a_m0_ready, a_m1_ready, a_s_valid, a_bus_err, a_err_master;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
    logic [3:0]  a_s_wstrb;
    logic        b_m0_ready, b_m1_ready, b_s_valid, b_bus_err, b_err_master;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
    logic [3:0]  b_s_wstrb;

    int tests = 0;
    int fails = 0;

    sram_bus_arbiter #(.ADDR_W(32), .TIMEOUT(8), .RR_EN(1'b1), .ERR_DATA(32'hDEAD_BEEF)) u_a (
        .clk(clk), .resetn(resetn),
        .m0_mem_valid(m0_valid), .m0_mem_addr(m0_addr), .m0_mem_wdata(m0_wdata), .m0_mem_wstrb(m0_wstrb),
        .m0_mem_ready(a_m0_ready), .m0_mem_rdata(a_m0_rdata),
        .m1_mem_valid(m1_valid), .m1_mem_addr(m1_addr), .m1_mem_wdata(m1_wdata), .m1_mem_wstrb(m1_wstrb),
        .m1_mem_ready(a_m1_ready), .m1_mem_rdata(a_m1_rdata),
        .s_mem_valid(a_s_valid), .s_mem_addr(a_s_addr), .s_mem_wdata(a_s_wdata), .s_mem_wstrb(a_s_wstrb),
        .s_mem_ready(s_ready), .s_mem_rdata(s_rdata),
        .bus_err(a_bus_err), .err_master(a_err_master)
    );

    sram_bus_arbiter #(.ADDR_W(32), .TIMEOUT(8), .RR_EN(1'b0), .ERR_DATA(32'hDEAD_BEEF)) u_b (
        .clk(clk), .resetn(resetn),
        .m0_mem_valid(m0_valid), .m0_mem_addr(m0_addr), .m0_mem_wdata(m0_wdata), .m0_mem_wstrb(m0_wstrb),
        .m0_mem_ready(b_m0_ready), .m0_mem_rdata(b_m0_rdata),
        .m1_mem_valid(m1_valid), .m1_mem_addr(m1_addr), .m1_mem_wdata(m1_wdata), .m1_mem_wstrb(m1_wstrb),
        .m1_mem_ready(b_m1_ready), .m1_mem_rdata(b_m1_rdata),
        .s_mem_valid(b_s_valid), .s_mem_addr(b_s_addr), .s_mem_wdata(b_s_wdata), .s_mem_wstrb(b_s_wstrb),
        .s_mem_ready(s_ready), .s_mem_rdata(s_rdata),
        .bus_err(b_bus_err), .err_master(b_err_master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 2 time units later
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // From IDLE with requests already presented: one grant, slave answers in the
    // first granted cycle, then the DONE cycle, then back in IDLE.
    task automatic grant_cycle(input logic exp_id, input logic [31:0] exp_addr,
                               input logic [31:0] rd, input bit chk_b);
        cyc();
        chk("gnt_valid", a_s_valid, 1);
        chk("gnt_addr", a_s_addr, exp_addr);
        s_ready = 1'b1;
        s_rdata = rd;
        #1;
        chk("gnt_ready_sel", exp_id ? a_m1_ready : a_m0_ready, 1);
        chk("gnt_ready_other", exp_id ? a_m0_ready : a_m1_ready, 0);
        chk("gnt_rdata_sel", exp_id ? a_m1_rdata : a_m0_rdata, rd);
        chk("gnt_rdata_other", exp_id ? a_m0_rdata : a_m1_rdata, 0);
        if (chk_b) begin
            chk("fixed_m0_ready", b_m0_ready, 1);
            chk("fixed_m1_ready", b_m1_ready, 0);
            chk("fixed_addr", b_s_addr, 32'h100);
        end
        cyc();
        s_ready = 1'b0;
        s_rdata = '0;
        #1;
        chk("done_valid_low", a_s_valid, 0);
        chk("done_ready_low", exp_id ? a_m1_ready : a_m0_ready, 0);
        cyc();
    endtask

    initial begin
        resetn = 1'b0;
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst_s_valid", a_s_valid, 0);
        chk("rst_m0_ready", a_m0_ready, 0);
        chk("rst_m1_ready", a_m1_ready, 0);
        chk("rst_bus_err", a_bus_err, 0);
        chk("rst_err_master", a_err_master, 0);
        resetn = 1'b1;
        cyc();
        chk("idle_s_valid", a_s_valid, 0);

        // m0 read alone, SRAM answers in first granted cycle
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        #1;
        chk("idle_no_comb_grant", a_s_valid, 0);
        grant_cycle(1'b0, 32'h100, 32'h1234_5678, 1'b0);
        m0_valid = 1'b0;

        // Reset asserted in the middle of a grant
        cyc();
        m0_valid = 1'b1; m0_addr = 32'h500;
        cyc();
        chk("pre_rst_gnt_valid", a_s_valid, 1);
        s_ready = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst_s_valid", a_s_valid, 0);
        chk("midrst_m0_ready", a_m0_ready, 0);
        chk("midrst_bus_err", a_bus_err, 0);
        chk("midrst_fixed_s_valid", b_s_valid, 0);
        s_ready = 1'b0;
        m0_valid = 1'b0;
        cyc();
        resetn = 1'b1;
        cyc();
        chk("post_rst_idle", a_s_valid, 0);

        // Both masters continuously requesting: RR alternates from m0, fixed picks m0
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h200; m1_wstrb = 4'hF; m1_wdata = 32'hA5A5_A5A5;
        grant_cycle(1'b0, 32'h100, 32'h1111_1111, 1'b1);
        grant_cycle(1'b1, 32'h200, 32'h2222_2222, 1'b1);
        grant_cycle(1'b0, 32'h100, 32'h3333_3333, 1'b1);
        grant_cycle(1'b1, 32'h200, 32'h4444_4444, 1'b1);

        // Watchdog expiry on an m1 write with the SRAM never answering
        m0_valid = 1'b0;
        m1_addr = 32'h300; m1_wstrb = 4'h3; m1_wdata = 32'hCAFE_F00D;
        cyc();
        chk("wr_wstrb_pass", a_s_wstrb, 32'h3);
        chk("wr_wdata_pass", a_s_wdata, 32'hCAFE_F00D);
        chk("wr_addr_pass", a_s_addr, 32'h300);
        for (int i = 1; i < 8; i++) begin
            chk("wdog_pre_ready", a_m1_ready, 0);
            chk("wdog_pre_err", a_bus_err, 0);
            cyc();
        end
        chk("wdog_ready", a_m1_ready, 1);
        chk("wdog_rdata", a_m1_rdata, 32'hDEAD_BEEF);
        chk("wdog_bus_err", a_bus_err, 1);
        chk("wdog_m0_ready", a_m0_ready, 0);
        chk("wdog_fixed_bus_err", b_bus_err, 1);
        cyc();
        chk("wdog_err_pulse_end", a_bus_err, 0);
        chk("wdog_err_master", a_err_master, 1);
        chk("wdog_done_valid", a_s_valid, 0);
        chk("wdog_done_ready", a_m1_ready, 0);
        m1_valid = 1'b0;
        cyc();

        // Slave ready in the same cycle the watchdog would fire: normal completion
        m0_valid = 1'b1; m0_addr = 32'h400; m0_wstrb = 4'h0;
        cyc();
        for (int i = 1; i < 8; i++) begin
            chk("late_pre_ready", a_m0_ready, 0);
            cyc();
        end
        s_ready = 1'b1;
        s_rdata = 32'h0BAD_F00D;
        #1;
        chk("late_ready", a_m0_ready, 1);
        chk("late_rdata", a_m0_rdata, 32'h0BAD_F00D);
        chk("late_no_err", a_bus_err, 0);
        chk("late_err_master_sticky", a_err_master, 1);
        cyc();
        s_ready = 1'b0;
        s_rdata = '0;
        m0_valid = 1'b0;
        #1;
        chk("late_done_valid", a_s_valid, 0);
        chk("late_done_err", a_bus_err, 0);
        cyc();

        // Master withdrawing valid mid-grant gets no ready and the arbiter idles
        m1_valid = 1'b1; m1_addr = 32'h600; m1_wstrb = 4'h0;
        cyc();
        chk("drop_gnt_valid", a_s_valid, 1);
        m1_valid = 1'b0;
        s_ready = 1'b1;
        #1;
        chk("drop_no_ready", a_m1_ready, 0);
        cyc();
        s_ready = 1'b0;
        #1;
        chk("drop_idle_valid", a_s_valid, 0);
        chk("drop_idle_ready", a_m1_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
